// File: rtl/x_top_rv32i_rf_arb_if.sv
// Bus bundle between decode/write-back, the register-file arbiter and the register file.
// The slave modport is the arbiter; the master modport is the requester / register-file side.
interface x_top_rv32i_rf_arb_if;
  logic        i_rd_valid;
  logic        o_rd_ready;
  logic [4:0]  i_rd_rs1;
  logic [4:0]  i_rd_rs2;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rs1_data;
  logic [31:0] o_rsp_rs2_data;
  logic        i_wr_valid;
  logic        o_wr_ready;
  logic [4:0]  i_wr_rd;
  logic [31:0] i_wr_data;
  logic        o_rf_wnr;
  logic [4:0]  o_rf_rs1;
  logic [4:0]  o_rf_rs2;
  logic [4:0]  o_rf_rd;
  logic [31:0] o_rf_rd_data;
  logic [31:0] i_rf_rs1_data;
  logic [31:0] i_rf_rs2_data;
  logic        o_init_done;

  modport slave (
    input  i_rd_valid, i_rd_rs1, i_rd_rs2,
    input  i_wr_valid, i_wr_rd, i_wr_data,
    input  i_rf_rs1_data, i_rf_rs2_data,
    output o_rd_ready, o_rsp_valid, o_rsp_rs1_data, o_rsp_rs2_data,
    output o_wr_ready, o_rf_wnr, o_rf_rs1, o_rf_rs2, o_rf_rd, o_rf_rd_data,
    output o_init_done
  );

  modport master (
    output i_rd_valid, i_rd_rs1, i_rd_rs2,
    output i_wr_valid, i_wr_rd, i_wr_data,
    output i_rf_rs1_data, i_rf_rs2_data,
    input  o_rd_ready, o_rsp_valid, o_rsp_rs1_data, o_rsp_rs2_data,
    input  o_wr_ready, o_rf_wnr, o_rf_rs1, o_rf_rs2, o_rf_rd, o_rf_rd_data,
    input  o_init_done
  );
endinterface

// File: rtl/x_top_rv32i_rf_arb.sv
// Single-port rv32i register-file sequencer: zero-fill sweep after reset, then per-cycle
// arbitration between operand reads and a small write-back queue with hazard and starvation guards.
module x_top_rv32i_rf_arb #(
  parameter int WQ_DEPTH   = 2,
  parameter int STARVE_MAX = 4,
  parameter bit INIT_EN    = 1'b1
) (
  input logic                 i_clk,
  input logic                 i_nrst,
  x_top_rv32i_rf_arb_if.slave bus
);

  localparam int PTR_W = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX + 1) : 1;

  typedef enum logic {ST_INIT, ST_RUN} state_e;
  localparam state_e RESET_STATE = INIT_EN ? ST_INIT : ST_RUN;

  state_e            state_q, state_d;
  logic [4:0]        sweep_q, sweep_d;
  logic              init_done_q, init_done_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [4:0]        wq_rd_q   [WQ_DEPTH];
  logic [4:0]        wq_rd_d   [WQ_DEPTH];
  logic [31:0]       wq_data_q [WQ_DEPTH];
  logic [31:0]       wq_data_d [WQ_DEPTH];

  logic              run;
  logic              q_empty;
  logic              q_full;
  logic              starve_hit;
  logic              hazard;
  logic              force_wr;
  logic              rd_cycle;
  logic              wr_cycle;
  logic              wr_ready;
  logic              push;
  logic [PTR_W-1:0]  slot_off;

  assign run        = (state_q == ST_RUN);
  assign q_empty    = (count_q == '0);
  assign q_full     = (count_q == CNT_W'(WQ_DEPTH));
  assign starve_hit = (starve_q == STV_W'(STARVE_MAX));

  // A slot is live when its distance from the head is below the occupancy count.
  always_comb begin
    hazard   = 1'b0;
    slot_off = '0;
    for (int i = 0; i < WQ_DEPTH; i++) begin
      slot_off = PTR_W'(i) - head_q;
      if ({1'b0, slot_off} < count_q) begin
        if ((bus.i_rd_rs1 != 5'd0 && wq_rd_q[i] == bus.i_rd_rs1) ||
            (bus.i_rd_rs2 != 5'd0 && wq_rd_q[i] == bus.i_rd_rs2)) begin
          hazard = 1'b1;
        end
      end
    end
  end

  assign force_wr = !q_empty && (starve_hit || hazard || q_full);
  assign rd_cycle = run && bus.i_rd_valid && !force_wr;
  assign wr_cycle = run && !rd_cycle && !q_empty;
  assign wr_ready = run && !q_full;
  assign push     = bus.i_wr_valid && wr_ready && (bus.i_wr_rd != 5'd0);

  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    init_done_d = init_done_q | run;
    head_d      = head_q + PTR_W'(wr_cycle);
    tail_d      = tail_q + PTR_W'(push);
    count_d     = count_q + CNT_W'(push) - CNT_W'(wr_cycle);
    rsp_valid_d = rd_cycle;
    starve_d    = starve_q;
    wq_rd_d     = wq_rd_q;
    wq_data_d   = wq_data_q;

    bus.o_rd_ready     = rd_cycle;
    bus.o_wr_ready     = wr_ready;
    bus.o_rsp_valid    = rsp_valid_q;
    bus.o_rsp_rs1_data = bus.i_rf_rs1_data;
    bus.o_rsp_rs2_data = bus.i_rf_rs2_data;
    bus.o_init_done    = init_done_q;
    bus.o_rf_wnr       = 1'b0;
    bus.o_rf_rs1       = 5'd0;
    bus.o_rf_rs2       = 5'd0;
    bus.o_rf_rd        = 5'd0;
    bus.o_rf_rd_data   = 32'd0;

    if (push) begin
      wq_rd_d[tail_q]   = bus.i_wr_rd;
      wq_data_d[tail_q] = bus.i_wr_data;
    end

    // The counter only measures how long a non-empty queue has been waiting.
    if (wr_cycle || q_empty) begin
      starve_d = '0;
    end else if (rd_cycle && !starve_hit) begin
      starve_d = starve_q + STV_W'(1);
    end

    case (state_q)
      ST_INIT: begin
        bus.o_rf_wnr = 1'b1;
        bus.o_rf_rd  = sweep_q;
        sweep_d      = sweep_q + 5'd1;
        if (sweep_q == 5'd31) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (rd_cycle) begin
          bus.o_rf_rs1 = bus.i_rd_rs1;
          bus.o_rf_rs2 = bus.i_rd_rs2;
        end else if (wr_cycle) begin
          bus.o_rf_wnr     = 1'b1;
          bus.o_rf_rd      = wq_rd_q[head_q];
          bus.o_rf_rd_data = wq_data_q[head_q];
        end
      end
      default: state_d = RESET_STATE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q     <= RESET_STATE;
      sweep_q     <= 5'd0;
      init_done_q <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      starve_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      init_done_q <= init_done_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Queue payload needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge i_clk) begin
    wq_rd_q   <= wq_rd_d;
    wq_data_q <= wq_data_d;
  end

endmodule

// File: tb/tb_x_top_rv32i_rf_arb.sv
// Directed bench for x_top_rv32i_rf_arb with a one-cycle-latency register-file model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_x_top_rv32i_rf_arb;

  logic i_clk = 1'b0;
  logic i_nrst;
  int   tests_run = 0;
  int   tests_failed = 0;

  logic [31:0] rf_mem [32];
  logic        rf_seeded = 1'b0;

  x_top_rv32i_rf_arb_if bus ();

  x_top_rv32i_rf_arb #(
    .WQ_DEPTH   (2),
    .STARVE_MAX (4),
    .INIT_EN    (1'b1)
  ) dut (
    .i_clk  (i_clk),
    .i_nrst (i_nrst),
    .bus    (bus.slave)
  );

  always #5 i_clk = ~i_clk;

  // Register-file model: seeded with junk so the sweep's zero-fill is observable.
  always @(posedge i_clk) begin
    if (!rf_seeded) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= 32'hBAD0_0000 | 32'(i);
      rf_seeded <= 1'b1;
    end else if (bus.o_rf_wnr) begin
      rf_mem[bus.o_rf_rd] <= bus.o_rf_rd_data;
    end
    bus.i_rf_rs1_data <= (bus.o_rf_rs1 == 5'd0) ? 32'd0 : rf_mem[bus.o_rf_rs1];
    bus.i_rf_rs2_data <= (bus.o_rf_rs2 == 5'd0) ? 32'd0 : rf_mem[bus.o_rf_rs2];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rdv, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic wrv, input logic [4:0] wrd, input logic [31:0] wdata);
    bus.i_rd_valid = rdv;
    bus.i_rd_rs1   = rs1;
    bus.i_rd_rs2   = rs2;
    bus.i_wr_valid = wrv;
    bus.i_wr_rd    = wrd;
    bus.i_wr_data  = wdata;
  endtask

  task automatic nextCycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic sampleCycle();
    @(negedge i_clk);
  endtask

  task automatic runSweep(input string tag);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
    for (int k = 0; k < 32; k++) begin
      sampleCycle();
      checkOutput($sformatf("%s_wnr%0d", tag, k), 32'(bus.o_rf_wnr), 32'd1);
      checkOutput($sformatf("%s_rd%0d", tag, k), 32'(bus.o_rf_rd), 32'(k));
      checkOutput($sformatf("%s_data%0d", tag, k), bus.o_rf_rd_data, 32'd0);
      checkOutput($sformatf("%s_wrrdy%0d", tag, k), 32'(bus.o_wr_ready), 32'd0);
      if (k == 31) checkOutput($sformatf("%s_done_early", tag), 32'(bus.o_init_done), 32'd0);
      nextCycle();
    end
    sampleCycle();
    checkOutput($sformatf("%s_done", tag), 32'(bus.o_init_done), 32'd1);
    checkOutput($sformatf("%s_wrrdy_end", tag), 32'(bus.o_wr_ready), 32'd1);
    checkOutput($sformatf("%s_idle_wnr", tag), 32'(bus.o_rf_wnr), 32'd0);
    nextCycle();
  endtask

  initial begin
    i_nrst = 1'b0;
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
    repeat (3) @(posedge i_clk);
    sampleCycle();
    checkOutput("rst_rd_ready", 32'(bus.o_rd_ready), 32'd0);
    checkOutput("rst_wr_ready", 32'(bus.o_wr_ready), 32'd0);
    checkOutput("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    checkOutput("rst_init_done", 32'(bus.o_init_done), 32'd0);
    checkOutput("rst_wnr", 32'(bus.o_rf_wnr), 32'd1);
    checkOutput("rst_rf_rd", 32'(bus.o_rf_rd), 32'd0);
    checkOutput("rst_rf_rs1", 32'(bus.o_rf_rs1), 32'd0);
    nextCycle();
    i_nrst = 1'b1;
    runSweep("sweep");

    // Read x5 after the sweep: must be zero.
    applyStimulus(1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 32'd0);
    sampleCycle();
    checkOutput("x5_rd_ready", 32'(bus.o_rd_ready), 32'd1);
    checkOutput("x5_rf_rs1", 32'(bus.o_rf_rs1), 32'd5);
    checkOutput("x5_wnr", 32'(bus.o_rf_wnr), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
    sampleCycle();
    checkOutput("x5_rsp_valid", 32'(bus.o_rsp_valid), 32'd1);
    checkOutput("x5_rsp_data", bus.o_rsp_rs1_data, 32'd0);
    nextCycle();
    sampleCycle();
    checkOutput("x5_rsp_drop", 32'(bus.o_rsp_valid), 32'd0);
    nextCycle();

    // Write x3 then read x3: hazard forces the write first.
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 32'hDEAD_BEEF);
    sampleCycle();
    checkOutput("raw_wr_ready", 32'(bus.o_wr_ready), 32'd1);
    checkOutput("raw_no_pass", 32'(bus.o_rf_wnr), 32'd0);
    nextCycle();
    applyStimulus(1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 32'd0);
    sampleCycle();
    checkOutput("raw_rd_blocked", 32'(bus.o_rd_ready), 32'd0);
    checkOutput("raw_wnr", 32'(bus.o_rf_wnr), 32'd1);
    checkOutput("raw_rf_rd", 32'(bus.o_rf_rd), 32'd3);
    checkOutput("raw_rf_data", bus.o_rf_rd_data, 32'hDEAD_BEEF);
    nextCycle();
    sampleCycle();
    checkOutput("raw_rd_ready", 32'(bus.o_rd_ready), 32'd1);
    checkOutput("raw_rf_rs1", 32'(bus.o_rf_rs1), 32'd3);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
    sampleCycle();
    checkOutput("raw_rsp_valid", 32'(bus.o_rsp_valid), 32'd1);
    checkOutput("raw_rsp_data", bus.o_rsp_rs1_data, 32'hDEAD_BEEF);
    nextCycle();

    // Write to x0 is swallowed.
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'h1234_5678);
    sampleCycle();
    checkOutput("x0_wr_ready", 32'(bus.o_wr_ready), 32'd1);
    checkOutput("x0_wnr_a", 32'(bus.o_rf_wnr), 32'd0);
    nextCycle();
    applyStimulus(1'b1, 5'd0, 5'd5, 1'b0, 5'd0, 32'd0);
    sampleCycle();
    checkOutput("x0_wnr_b", 32'(bus.o_rf_wnr), 32'd0);
    checkOutput("x0_rd_ready", 32'(bus.o_rd_ready), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
    sampleCycle();
    checkOutput("x0_wnr_c", 32'(bus.o_rf_wnr), 32'd0);
    checkOutput("x0_rsp_data", bus.o_rsp_rs1_data, 32'd0);
    nextCycle();

    // Starvation: one queued write, continuous non-hazard reads.
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 5'd7, 32'h0000_0777);
    sampleCycle();
    checkOutput("stv_rd_ready0", 32'(bus.o_rd_ready), 32'd1);
    checkOutput("stv_wr_ready0", 32'(bus.o_wr_ready), 32'd1);
    nextCycle();
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 32'd0);
    for (int j = 1; j <= 4; j++) begin
      sampleCycle();
      checkOutput($sformatf("stv_rd_ready%0d", j), 32'(bus.o_rd_ready), 32'd1);
      checkOutput($sformatf("stv_wnr%0d", j), 32'(bus.o_rf_wnr), 32'd0);
      nextCycle();
    end
    sampleCycle();
    checkOutput("stv_force_rdy", 32'(bus.o_rd_ready), 32'd0);
    checkOutput("stv_force_wnr", 32'(bus.o_rf_wnr), 32'd1);
    checkOutput("stv_force_rd", 32'(bus.o_rf_rd), 32'd7);
    checkOutput("stv_force_data", bus.o_rf_rd_data, 32'h0000_0777);
    nextCycle();
    sampleCycle();
    checkOutput("stv_resume", 32'(bus.o_rd_ready), 32'd1);
    checkOutput("stv_rsp_gap", 32'(bus.o_rsp_valid), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
    nextCycle();

    // Queue full under continuous reads.
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 5'd8, 32'h0000_0088);
    sampleCycle();
    checkOutput("full_wr_ready_a", 32'(bus.o_wr_ready), 32'd1);
    checkOutput("full_rd_ready_a", 32'(bus.o_rd_ready), 32'd1);
    nextCycle();
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 5'd9, 32'h0000_0099);
    sampleCycle();
    checkOutput("full_wr_ready_b", 32'(bus.o_wr_ready), 32'd1);
    checkOutput("full_rd_ready_b", 32'(bus.o_rd_ready), 32'd1);
    nextCycle();
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 32'd0);
    sampleCycle();
    checkOutput("full_wr_ready_c", 32'(bus.o_wr_ready), 32'd0);
    checkOutput("full_rd_ready_c", 32'(bus.o_rd_ready), 32'd0);
    checkOutput("full_wnr_c", 32'(bus.o_rf_wnr), 32'd1);
    checkOutput("full_rf_rd_c", 32'(bus.o_rf_rd), 32'd8);
    checkOutput("full_data_c", bus.o_rf_rd_data, 32'h0000_0088);
    nextCycle();
    sampleCycle();
    checkOutput("full_wr_ready_d", 32'(bus.o_wr_ready), 32'd1);
    checkOutput("full_rd_ready_d", 32'(bus.o_rd_ready), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
    sampleCycle();
    checkOutput("full_wnr_e", 32'(bus.o_rf_wnr), 32'd1);
    checkOutput("full_rf_rd_e", 32'(bus.o_rf_rd), 32'd9);
    checkOutput("full_data_e", bus.o_rf_rd_data, 32'h0000_0099);
    nextCycle();
    sampleCycle();
    checkOutput("full_drained", 32'(bus.o_rf_wnr), 32'd0);
    nextCycle();

    // Reset with two queued writes and a pending response.
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 5'd10, 32'h0000_00AA);
    nextCycle();
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 5'd11, 32'h0000_00BB);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
    checkOutput("mid_pre_rsp", 32'(bus.o_rsp_valid), 32'd1);
    checkOutput("mid_pre_full", 32'(bus.o_wr_ready), 32'd0);
    i_nrst = 1'b0;
    #1;
    checkOutput("mid_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    checkOutput("mid_wnr", 32'(bus.o_rf_wnr), 32'd1);
    checkOutput("mid_rf_rd", 32'(bus.o_rf_rd), 32'd0);
    checkOutput("mid_wr_ready", 32'(bus.o_wr_ready), 32'd0);
    checkOutput("mid_init_done", 32'(bus.o_init_done), 32'd0);
    nextCycle();
    i_nrst = 1'b1;
    runSweep("resweep");
    applyStimulus(1'b1, 5'd10, 5'd11, 1'b0, 5'd0, 32'd0);
    sampleCycle();
    checkOutput("mid_rd_ready", 32'(bus.o_rd_ready), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
    sampleCycle();
    checkOutput("mid_x10", bus.o_rsp_rs1_data, 32'd0);
    checkOutput("mid_x11", bus.o_rsp_rs2_data, 32'd0);
    checkOutput("mid_no_wnr", 32'(bus.o_rf_wnr), 32'd0);
    nextCycle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
